// File: rtl/remap_pkg.sv
// Shared constants and types for the remap bilinear sampler: pixel format,
// coordinate format, tap ordering and the sampler FSM states.
package remap_pkg;

    localparam int COORD_W       = 16;
    localparam int FRAC_BITS_DEF = 4;

    localparam int PIX_W    = 16;
    localparam int R_LSB    = 11;
    localparam int R_W      = 5;
    localparam int G_LSB    = 5;
    localparam int G_W      = 6;
    localparam int B_LSB    = 0;
    localparam int B_W      = 5;
    localparam int CH_W_MAX = 6;

    localparam int         NUM_TAPS = 4;
    localparam logic [1:0] TAP_TL   = 2'd0;
    localparam logic [1:0] TAP_TR   = 2'd1;
    localparam logic [1:0] TAP_BL   = 2'd2;
    localparam logic [1:0] TAP_BR   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_BLEND,
        ST_OUT
    } state_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

endpackage

// File: rtl/bilinear_blend_rgb565.sv
// Combinational bilinear weighting of four RGB565 taps with round-to-nearest;
// the parent registers the result.
module bilinear_blend_rgb565
    import remap_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic [NUM_TAPS-1:0][PIX_W-1:0] taps_i,
    input  logic [FRAC_BITS-1:0]           fx_i,
    input  logic [FRAC_BITS-1:0]           fy_i,
    output logic [PIX_W-1:0]               pixel_o
);

    localparam int ACC_W = CH_W_MAX + 2 * FRAC_BITS + 1;
    localparam int ONE   = 1 << FRAC_BITS;

    logic [ACC_W-1:0] wx0, wx1, wy0, wy1;

    assign wx1 = ACC_W'(fx_i);
    assign wx0 = ACC_W'(ONE) - wx1;
    assign wy1 = ACC_W'(fy_i);
    assign wy0 = ACC_W'(ONE) - wy1;

    function automatic logic [CH_W_MAX-1:0] field(input logic [PIX_W-1:0] p,
                                                  input int lsb, input int w);
        logic [PIX_W-1:0] m;
        m = PIX_W'((1 << w) - 1);
        return CH_W_MAX'((p >> lsb) & m);
    endfunction

    // Weights sum to ONE*ONE, so the result never exceeds the channel maximum.
    function automatic logic [CH_W_MAX-1:0] blend_field(
        input logic [NUM_TAPS-1:0][PIX_W-1:0] t,
        input int lsb, input int w,
        input logic [ACC_W-1:0] x0w, x1w, y0w, y1w
    );
        logic [ACC_W-1:0] top, bot, acc;
        top = ACC_W'(field(t[TAP_TL], lsb, w)) * x0w + ACC_W'(field(t[TAP_TR], lsb, w)) * x1w;
        bot = ACC_W'(field(t[TAP_BL], lsb, w)) * x0w + ACC_W'(field(t[TAP_BR], lsb, w)) * x1w;
        acc = top * y0w + bot * y1w + (ACC_W'(1) << (2 * FRAC_BITS - 1));
        return CH_W_MAX'(acc >> (2 * FRAC_BITS));
    endfunction

    assign pixel_o = {R_W'(blend_field(taps_i, R_LSB, R_W, wx0, wx1, wy0, wy1)),
                      G_W'(blend_field(taps_i, G_LSB, G_W, wx0, wx1, wy0, wy1)),
                      B_W'(blend_field(taps_i, B_LSB, B_W, wx0, wx1, wy0, wy1))};

endmodule

// File: rtl/remap_bilinear_sampler.sv
// Bilinear remap sampler: fetches the 2x2 RGB565 neighbourhood of each source
// coordinate from the frame buffer, blends it and emits one pixel with its sync.
module remap_bilinear_sampler
    import remap_pkg::*;
#(
    parameter int IMG_W     = 1280,
    parameter int IMG_H     = 720,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int ADDR_W    = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_src_x,
    input  logic [COORD_W-1:0] in_src_y,
    input  logic               in_de,
    input  logic               in_hs,
    input  logic               in_vs,
    output logic               mem_rd_req,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic               mem_rd_gnt,
    input  logic               mem_rd_valid,
    input  logic [PIX_W-1:0]   mem_rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIX_W-1:0]   out_pixel,
    output logic               out_de,
    output logic               out_hs,
    output logic               out_vs
);

    localparam int         INT_W   = COORD_W - FRAC_BITS;
    localparam logic [2:0] RSP_ALL = 3'(NUM_TAPS);

    state_t                        state_q;
    logic [INT_W-1:0]              x0_q, x1_q, y0_q, y1_q;
    logic [FRAC_BITS-1:0]          fx_q, fy_q;
    sync_t                         sync_q;
    logic [1:0]                    req_cnt_q;
    logic [2:0]                    rsp_cnt_q;
    logic [NUM_TAPS-1:0][PIX_W-1:0] taps_q;
    logic                          mem_rd_req_q;
    logic [ADDR_W-1:0]             mem_rd_addr_q;
    logic                          out_valid_q;
    logic [PIX_W-1:0]              out_pixel_q;
    sync_t                         out_sync_q;

    logic [INT_W-1:0]     in_x0, in_y0, in_x1, in_y1;
    logic [FRAC_BITS-1:0] in_fx, in_fy;
    logic                 in_bypass;
    logic [1:0]           next_tap_d;
    logic [ADDR_W-1:0]    next_addr_d;
    logic                 rsp_take;
    logic                 rsp_done_d;
    logic [PIX_W-1:0]     blend_pix;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [INT_W-1:0] x, input logic [INT_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
    endfunction

    assign in_x0     = in_src_x[COORD_W-1:FRAC_BITS];
    assign in_y0     = in_src_y[COORD_W-1:FRAC_BITS];
    assign in_fx     = in_src_x[FRAC_BITS-1:0];
    assign in_fy     = in_src_y[FRAC_BITS-1:0];
    assign in_x1     = (in_x0 == INT_W'(IMG_W - 1)) ? in_x0 : in_x0 + INT_W'(1);
    assign in_y1     = (in_y0 == INT_W'(IMG_H - 1)) ? in_y0 : in_y0 + INT_W'(1);
    assign in_bypass = !in_de || (in_x0 >= INT_W'(IMG_W)) || (in_y0 >= INT_W'(IMG_H));

    // Tap order TL, TR, BL, BR: bit 0 picks the right column, bit 1 the lower row.
    assign next_tap_d  = req_cnt_q + 2'd1;
    assign next_addr_d = pix_addr((next_tap_d == TAP_TR || next_tap_d == TAP_BR) ? x1_q : x0_q,
                                  (next_tap_d == TAP_BL || next_tap_d == TAP_BR) ? y1_q : y0_q);

    assign rsp_take   = (state_q == ST_REQ || state_q == ST_WAIT) && mem_rd_valid && (rsp_cnt_q < RSP_ALL);
    assign rsp_done_d = (rsp_cnt_q == RSP_ALL) || ((rsp_cnt_q == RSP_ALL - 3'd1) && mem_rd_valid);

    bilinear_blend_rgb565 #(
        .FRAC_BITS (FRAC_BITS)
    ) u_blend (
        .taps_i  (taps_q),
        .fx_i    (fx_q),
        .fy_i    (fy_q),
        .pixel_o (blend_pix)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            x0_q          <= '0;
            x1_q          <= '0;
            y0_q          <= '0;
            y1_q          <= '0;
            fx_q          <= '0;
            fy_q          <= '0;
            sync_q        <= '0;
            req_cnt_q     <= '0;
            rsp_cnt_q     <= '0;
            mem_rd_req_q  <= 1'b0;
            mem_rd_addr_q <= '0;
            out_valid_q   <= 1'b0;
            out_pixel_q   <= '0;
            out_sync_q    <= '0;
        end else begin
            if (rsp_take) begin
                rsp_cnt_q <= rsp_cnt_q + 3'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x0_q      <= in_x0;
                        x1_q      <= in_x1;
                        y0_q      <= in_y0;
                        y1_q      <= in_y1;
                        fx_q      <= in_fx;
                        fy_q      <= in_fy;
                        sync_q    <= '{de: in_de, hs: in_hs, vs: in_vs};
                        req_cnt_q <= TAP_TL;
                        rsp_cnt_q <= '0;
                        if (in_bypass) begin
                            out_valid_q <= 1'b1;
                            out_pixel_q <= '0;
                            out_sync_q  <= '{de: in_de, hs: in_hs, vs: in_vs};
                            state_q     <= ST_OUT;
                        end else begin
                            mem_rd_req_q  <= 1'b1;
                            mem_rd_addr_q <= pix_addr(in_x0, in_y0);
                            state_q       <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_rd_gnt) begin
                        req_cnt_q <= next_tap_d;
                        if (req_cnt_q == TAP_BR) begin
                            mem_rd_req_q <= 1'b0;
                            state_q      <= ST_WAIT;
                        end else begin
                            mem_rd_addr_q <= next_addr_d;
                        end
                    end
                end
                ST_WAIT: begin
                    if (rsp_done_d) begin
                        state_q <= ST_BLEND;
                    end
                end
                ST_BLEND: begin
                    out_valid_q <= 1'b1;
                    out_pixel_q <= blend_pix;
                    out_sync_q  <= sync_q;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: tap storage has no reset; all four slots are rewritten before BLEND reads them.
    always_ff @(posedge clk) begin
        if (rsp_take) begin
            taps_q[rsp_cnt_q[1:0]] <= mem_rd_data;
        end
    end

    // Read data may only arrive while this beat still owes responses.
    rsp_in_window: assert property (@(posedge clk) disable iff (!rst_n) mem_rd_valid |-> rsp_take);

    assign in_ready    = rst_n && (state_q == ST_IDLE);
    assign mem_rd_req  = mem_rd_req_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign out_valid   = out_valid_q;
    assign out_pixel   = out_pixel_q;
    assign out_de      = out_sync_q.de;
    assign out_hs      = out_sync_q.hs;
    assign out_vs      = out_sync_q.vs;

endmodule

// File: doc/remap_bilinear_sampler.md
Name: remap_bilinear_sampler

Overview:
- Consumer of the corrected source-coordinate stream produced by the undistortion stage.
- For each display beat it fetches the 2x2 RGB565 neighbourhood around the fixed-point source coordinate from frame-buffer memory.
- It blends the four pixels bilinearly and emits one output pixel with de/hs/vs kept aligned.
- Sits between coordinate generation and the DVI/HDMI pixel encoder.

Parameters:
- IMG_W, 1280, source image width in pixels.
- IMG_H, 720, source image height in pixels.
- FRAC_BITS, 4, fractional bits in the coordinate format (unsigned, 16-FRAC_BITS integer bits).
- ADDR_W, 20, frame-buffer pixel address width.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  coordinate beat valid.
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- in_src_x  in  16  source X, unsigned fixed point.
- in_src_y  in  16  source Y, unsigned fixed point.
- in_de / in_hs / in_vs  in  1 each  sync sideband for this beat.
- mem_rd_req  out  1  read request.
- mem_rd_addr  out  ADDR_W  pixel address y*IMG_W+x.
- mem_rd_gnt  in  1  request accepted this cycle.
- mem_rd_valid  in  1  read data valid; in-order responses.
- mem_rd_data  in  16  RGB565 read data.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts.
- out_pixel  out  16  blended RGB565 pixel.
- out_de / out_hs / out_vs  out  1 each  sideband captured with the beat.

Behaviour:
- Reset (rst_n low at posedge clk):
  - State IDLE.
  - out_valid, out_pixel, out_de/hs/vs, mem_rd_req, mem_rd_addr, and the request and response counters all cleared to 0.
  - in_ready is 0 while rst_n is low.
  - Reset mid-operation abandons the beat. The memory is reset by the same rst_n, so no stale responses arrive afterwards.
- in_ready = 1 only in IDLE (out of reset). On acceptance, capture coordinates and sideband.
- Decode:
  - x0 = in_src_x >> FRAC_BITS; fx = low FRAC_BITS bits. Same for y0/fy.
- Bypass path (in_de=0, or x0>=IMG_W, or y0>=IMG_H):
  - No memory access.
  - IDLE -> OUT; out_valid asserted the next cycle with out_pixel=0x0000.
- Fetch path:
  - Neighbour coordinates: x1 = (x0==IMG_W-1) ? x0 : x0+1; y1 likewise (edge clamp).
  - IDLE -> REQ: issue TL(x0,y0), TR(x1,y0), BL(x0,y1), BR(x1,y1) in that order.
  - mem_rd_req is held with a stable address until mem_rd_gnt; advance to the next tap on gnt.
  - After the 4th gnt: REQ -> WAIT.
  - Responses are counted and stored in order from the first cycle, including while still in REQ.
  - 4th response received -> BLEND (one cycle) -> OUT.
- OUT:
  - out_valid=1; out_pixel and sideband held stable until out_ready.
  - On out_valid&&out_ready -> IDLE.
  - A new beat is accepted no earlier than the cycle after the handshake.
- Blend, per channel (R5, G6, B5 independently), with W=1<<FRAC_BITS:
  - c = ((TL*(W-fx)+TR*fx)*(W-fy) + (BL*(W-fx)+BR*fx)*fy + (1<<(2*FRAC_BITS-1))) >> (2*FRAC_BITS).
  - Intermediate width 6+2*FRAC_BITS+1 bits; no saturation is needed because the result cannot exceed the channel max.
- Minimum latency, acceptance to out_valid:
  - Bypass: 1 cycle.
  - Fetch: 4 gnt cycles + last response + 1 BLEND cycle.
- mem_rd_gnt is ignored when mem_rd_req=0.
- mem_rd_valid beyond 4 per beat is a protocol violation; a simulation assertion is required.

Decomposition:
- Package remap_pkg:
  - RGB565 field positions/widths.
  - FRAC_BITS default and coordinate-format constants.
  - FSM state enum (IDLE, REQ, WAIT, BLEND, OUT).
  - Tap index constants TL=0, TR=1, BL=2, BR=3.
- Sub-module bilinear_blend_rgb565: combinational 4-tap weighted blend.
  - Inputs: taps, fx, fy.
  - Output: pixel.
  - Registered by the parent in BLEND.

Test Plan:
1. Integer coordinate: x=0x0640 (100.0), y=0x0320 (50.0), de=1 -> addresses 64100, 64101, 65380, 65381 in order; out_pixel equals the TL data (e.g. 0x1234).
2. Half-pixel blend: x=0x0648, y=0x0320; TL=BL=0x0000, TR=BR=0xFFFF -> out_pixel=0x8410 (R16, G32, B16).
3. Out of range: x=0x5000 (1280.0), de=1 -> no mem_rd_req; out_valid 1 cycle after accept; out_pixel=0x0000, out_de=1.
4. Edge clamp: x=0x4FF8, y=0x2CF8 (1279.5, 719.5) -> all four addresses 921599; out_pixel equals that data.
5. Blanking beat: in_de=0, in_hs=1, in_vs=0 -> no fetch; out_de=0, out_hs=1, out_pixel=0.
6. Stalls:
   - mem_rd_gnt low 3 cycles per request: mem_rd_addr held stable.
   - Responses delayed 5 cycles.
   - out_ready low 10 cycles: out_pixel and sideband held, in_ready=0, no new request.
   - Reset asserted in WAIT -> next cycle in IDLE, all outputs 0.
